// File: rtl/dk4004_pkg.sv
// Shared definitions for the 4004 core: nibble type and data bus buffer path codes.
package dk4004_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Direction codes for the data bus buffer.
    localparam logic [1:0] DBB_HOLD = 2'b00;
    localparam logic [1:0] DBB_IN   = 2'b01;
    localparam logic [1:0] DBB_OUT  = 2'b10;
    localparam logic [1:0] DBB_LOOP = 2'b11;

endpackage

// File: rtl/nibble_latch.sv
// Nibble-wide register with asynchronous active-low clear and a load enable.
module nibble_latch
    import dk4004_pkg::*;
#(
    parameter int WIDTH = NIBBLE_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: take the new data only when loading, otherwise keep.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end
    end

    // State register, cleared immediately when reset is asserted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/data_bus_buffer.sv
// 4004 data bus buffer: latches pin data inward or internal data outward on
// the rising edge of clk_2, selected by a direction code and a global enable.
// Optional macro DATA_BUS_BUFFER_TRISTATE_EN releases outputs to high-Z when
// they are not being driven (for shared-bus integration).
module data_bus_buffer
    import dk4004_pkg::*;
#(
    parameter int WIDTH = NIBBLE_W
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] D0_D3,
    input  logic             data_bus_buffer_enable,
    input  logic [1:0]       data_bus_buffer_path,
    input  logic [WIDTH-1:0] internal_bus_in,
    output logic [WIDTH-1:0] data_bus,
    output logic [WIDTH-1:0] D0_D3_out,
    output logic             D0_D3_oe
);

    logic             in_load;
    logic             out_load;
    logic             pin_oe;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_latch_q;
    logic [WIDTH-1:0] out_latch_q;

    // Decode enable and path into latch loads and pin drive. Any path value
    // that is not a known IN/OUT/LOOP code (including X/Z) falls to HOLD.
    always_comb begin
        in_load  = 1'b0;
        out_load = 1'b0;
        pin_oe   = 1'b0;
        in_data  = D0_D3;
        if (data_bus_buffer_enable) begin
            case (data_bus_buffer_path)
                DBB_IN: begin
                    in_load = 1'b1;
                end
                DBB_OUT: begin
                    out_load = 1'b1;
                    pin_oe   = 1'b1;
                end
                DBB_LOOP: begin
                    in_load  = 1'b1;
                    out_load = 1'b1;
                    in_data  = internal_bus_in;
                end
                default: begin
                end
            endcase
        end
    end

    nibble_latch #(.WIDTH(WIDTH)) u_in_latch (
        .clk_i  (clk_2),
        .rst_ni (reset_n),
        .load_i (in_load),
        .d_i    (in_data),
        .q_o    (in_latch_q)
    );

    nibble_latch #(.WIDTH(WIDTH)) u_out_latch (
        .clk_i  (clk_2),
        .rst_ni (reset_n),
        .load_i (out_load),
        .d_i    (internal_bus_in),
        .q_o    (out_latch_q)
    );

    assign D0_D3_oe = pin_oe;

`ifdef DATA_BUS_BUFFER_TRISTATE_EN
    // Internal bus is driven only while the inbound latch is the active source.
    logic bus_drive;
    assign bus_drive = data_bus_buffer_enable &&
                       ((data_bus_buffer_path == DBB_IN) || (data_bus_buffer_path == DBB_LOOP));
    assign data_bus  = bus_drive ? in_latch_q : {WIDTH{1'bz}};
    assign D0_D3_out = pin_oe ? out_latch_q : {WIDTH{1'bz}};
`else
    assign data_bus  = in_latch_q;
    assign D0_D3_out = out_latch_q;
`endif

endmodule

// File: tb/tb_data_bus_buffer.sv
// Directed bench for data_bus_buffer (default build, DATA_BUS_BUFFER_TRISTATE_EN undefined).
module tb_data_bus_buffer;

    logic       clk_2;
    logic       reset_n;
    logic [3:0] D0_D3;
    logic       data_bus_buffer_enable;
    logic [1:0] data_bus_buffer_path;
    logic [3:0] internal_bus_in;
    logic [3:0] data_bus;
    logic [3:0] D0_D3_out;
    logic       D0_D3_oe;

    int checks;
    int errors;

    // Model of the latches used for the randomized sweep.
    logic [3:0] exp_in;
    logic [3:0] exp_out;
    logic       exp_oe;

    data_bus_buffer #(.WIDTH(4)) dut (
        .clk_2                  (clk_2),
        .reset_n                (reset_n),
        .D0_D3                  (D0_D3),
        .data_bus_buffer_enable (data_bus_buffer_enable),
        .data_bus_buffer_path   (data_bus_buffer_path),
        .internal_bus_in        (internal_bus_in),
        .data_bus               (data_bus),
        .D0_D3_out              (D0_D3_out),
        .D0_D3_oe               (D0_D3_oe)
    );

    // Clock: 10 time unit period.
    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, away from the capturing edge.
    task automatic drive(input logic en, input logic [1:0] path, input logic [3:0] pins,
                         input logic [3:0] ibus);
        @(negedge clk_2);
        data_bus_buffer_enable = en;
        data_bus_buffer_path   = path;
        D0_D3                  = pins;
        internal_bus_in        = ibus;
        #1;
    endtask

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        data_bus_buffer_enable = 1'b1;
        data_bus_buffer_path   = 2'b01;
        D0_D3                  = 4'hF;
        internal_bus_in        = 4'hF;

        // Reset holds latches at zero even with IN path enabled.
        #1;
        check("reset_data_bus", data_bus, 4'h0);
        step();
        step();
        check("reset_data_bus_edge", data_bus, 4'h0);
        check("reset_pin_out", D0_D3_out, 4'h0);
        check("reset_oe", {3'b0, D0_D3_oe}, 4'h0);

        // Release with enable low: nothing captured.
        drive(1'b0, 2'b01, 4'hF, 4'hF);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 2'(i % 4), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            check("dis_oe", {3'b0, D0_D3_oe}, 4'h0);
            step();
            check("dis_data_bus", data_bus, 4'h0);
            check("dis_pin_out", D0_D3_out, 4'h0);
        end

        // IN path: A then 5, each visible one edge later.
        drive(1'b1, 2'b01, 4'hA, 4'h0);
        check("in_oe", {3'b0, D0_D3_oe}, 4'h0);
        check("in_before_edge", data_bus, 4'h0);
        step();
        check("in_a", data_bus, 4'hA);
        drive(1'b1, 2'b01, 4'h5, 4'h0);
        step();
        check("in_5", data_bus, 4'h5);
        check("in_pin_out", D0_D3_out, 4'h0);

        // OUT path: oe immediate, pin data after one edge, data_bus untouched.
        drive(1'b1, 2'b10, 4'hE, 4'h3);
        check("out_oe_now", {3'b0, D0_D3_oe}, 4'h1);
        check("out_before_edge", D0_D3_out, 4'h0);
        step();
        check("out_pin", D0_D3_out, 4'h3);
        check("out_data_bus", data_bus, 4'h5);

        // HOLD: pin changes ignored.
        drive(1'b1, 2'b00, 4'h9, 4'hB);
        check("hold_oe", {3'b0, D0_D3_oe}, 4'h0);
        step();
        check("hold_data_bus", data_bus, 4'h5);
        check("hold_pin", D0_D3_out, 4'h3);

        // LOOP: internal value into both latches, pins not driven.
        drive(1'b1, 2'b11, 4'h1, 4'hC);
        check("loop_oe", {3'b0, D0_D3_oe}, 4'h0);
        step();
        check("loop_data_bus", data_bus, 4'hC);
        check("loop_pin", D0_D3_out, 4'hC);

        // Unknown path behaves as HOLD.
        drive(1'b1, 2'bxx, 4'h7, 4'h7);
        check("x_oe", {3'b0, D0_D3_oe}, 4'h0);
        step();
        check("x_data_bus", data_bus, 4'hC);
        check("x_pin", D0_D3_out, 4'hC);

        // Enable low with OUT path: hold, no pin drive.
        drive(1'b0, 2'b10, 4'h2, 4'h6);
        check("dis_out_oe", {3'b0, D0_D3_oe}, 4'h0);
        step();
        check("dis_out_pin", D0_D3_out, 4'hC);

        // Enable rising with OUT path: captures on first enabled edge.
        drive(1'b1, 2'b10, 4'h2, 4'h6);
        check("rise_oe", {3'b0, D0_D3_oe}, 4'h1);
        step();
        check("rise_pin", D0_D3_out, 4'h6);

        // Path sweep against a small model; enable asserted partway through.
        exp_in  = 4'hC;
        exp_out = 4'h6;
        for (int i = 0; i < 16; i++) begin
            logic       en;
            logic [1:0] path;
            logic [3:0] pins;
            logic [3:0] ibus;
            en   = (i >= 4);
            path = 2'(i % 4);
            pins = 4'($urandom_range(0, 15));
            ibus = 4'($urandom_range(0, 15));
            drive(en, path, pins, ibus);
            exp_oe = en && (path == 2'b10);
            check("sweep_oe", {3'b0, D0_D3_oe}, {3'b0, exp_oe});
            if (en) begin
                if (path == 2'b01) exp_in = pins;
                if (path == 2'b10) exp_out = ibus;
                if (path == 2'b11) begin
                    exp_in  = ibus;
                    exp_out = ibus;
                end
            end
            step();
            check("sweep_data_bus", data_bus, exp_in);
            check("sweep_pin", D0_D3_out, exp_out);
        end

        // Reset mid-transfer: latches clear at once, capture lost.
        drive(1'b1, 2'b11, 4'h0, 4'hD);
        step();
        check("pre_reset_data_bus", data_bus, 4'hD);
        drive(1'b1, 2'b11, 4'h0, 4'h8);
        reset_n = 1'b0;
        #1;
        check("midreset_data_bus", data_bus, 4'h0);
        check("midreset_pin", D0_D3_out, 4'h0);
        step();
        check("midreset_edge", data_bus, 4'h0);

        // First edge after release captures if enabled.
        drive(1'b1, 2'b01, 4'h4, 4'h8);
        reset_n = 1'b1;
        step();
        check("release_capture", data_bus, 4'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
